// File: rtl/decode_pkg.sv
// Shared types and opcode constants for the RV32I decode stage.
package decode_pkg;

  localparam int DEC_XLEN = 32;

  typedef enum logic [3:0] {
    CODE_NONE   = 4'd0,
    CODE_OP     = 4'd1,
    CODE_OP_IMM = 4'd2,
    CODE_LOAD   = 4'd3,
    CODE_STORE  = 4'd4,
    CODE_BRANCH = 4'd5,
    CODE_JAL    = 4'd6,
    CODE_JALR   = 4'd7,
    CODE_LUI    = 4'd8,
    CODE_AUIPC  = 4'd9,
    CODE_SYSTEM = 4'd10,
    CODE_FENCE  = 4'd11
  } code_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_e;

  // opcode[6:2] values
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;

  // RV32 view of one decoded beat; the stage keeps an XLEN-wide equivalent.
  typedef struct packed {
    logic [DEC_XLEN-1:0] pc;
    logic [31:0]         instr;
    code_e               code;
    imm_sel_e            imm_sel;
    logic [DEC_XLEN-1:0] imm;
    logic                illegal;
  } dec_beat_t;

  // Raw 32-bit immediate for a given format, sign taken from instr[31].
  function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_sel_e s);
    logic [31:0] r;
    r = 32'd0;
    case (s)
      IMM_I:   r = {{20{i[31]}}, i[31:20]};
      IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   r = {i[31:12], 12'b0};
      IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational decode of one instruction word into class, format, immediate
// and illegal flag. Illegal words decode as class 0 with no immediate.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EN_SYSTEM = 1'b1
) (
  input  logic [31:0]     instr,
  output code_e           code,
  output imm_sel_e        imm_sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  code_e       code_raw;
  logic        sys_ok;
  logic [31:0] imm32;

  // classify opcode, then qualify legality and pick the immediate format
  always_comb begin
    code_raw = CODE_NONE;
    unique case (instr[6:2])
      OPC_OP:     code_raw = CODE_OP;
      OPC_OP_IMM: code_raw = CODE_OP_IMM;
      OPC_LOAD:   code_raw = CODE_LOAD;
      OPC_STORE:  code_raw = CODE_STORE;
      OPC_BRANCH: code_raw = CODE_BRANCH;
      OPC_JAL:    code_raw = CODE_JAL;
      OPC_JALR:   code_raw = CODE_JALR;
      OPC_LUI:    code_raw = CODE_LUI;
      OPC_AUIPC:  code_raw = CODE_AUIPC;
      OPC_SYSTEM: code_raw = CODE_SYSTEM;
      OPC_FENCE:  code_raw = CODE_FENCE;
      default:    code_raw = CODE_NONE;
    endcase

    sys_ok  = EN_SYSTEM || !(code_raw inside {CODE_SYSTEM, CODE_FENCE});
    illegal = (code_raw == CODE_NONE) || (instr[1:0] != 2'b11) || !sys_ok;
    code    = illegal ? CODE_NONE : code_raw;

    case (code)
      CODE_OP_IMM, CODE_LOAD, CODE_JALR, CODE_SYSTEM: imm_sel = IMM_I;
      CODE_STORE:                                     imm_sel = IMM_S;
      CODE_BRANCH:                                    imm_sel = IMM_B;
      CODE_LUI, CODE_AUIPC:                           imm_sel = IMM_U;
      CODE_JAL:                                       imm_sel = IMM_J;
      default:                                        imm_sel = IMM_NONE;
    endcase

    imm32 = imm_gen(instr, imm_sel);
    imm   = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: main output register plus an optional skid
// register so in_ready can be a flop while sustaining one beat per cycle.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EN_SYSTEM = 1'b1,
  parameter bit EN_SKID   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [3:0]      out_code,
  output logic [2:0]      out_imm_sel,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    code_e           code;
    imm_sel_e        imm_sel;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } beat_t;

  code_e           dec_code;
  imm_sel_e        dec_imm_sel;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  beat_t in_beat;
  beat_t main_q, main_d, skid_q, skid_d;
  logic  main_valid_q, main_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  in_ready_q, in_ready_d;
  logic  accept, drain;

  decode_comb #(.XLEN(XLEN), .EN_SYSTEM(EN_SYSTEM)) u_decode_comb (
    .instr   (in_instr),
    .code    (dec_code),
    .imm_sel (dec_imm_sel),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  // gather the decoded fields of the offered instruction into one beat
  always_comb begin
    in_beat         = '0;
    in_beat.pc      = in_pc;
    in_beat.instr   = in_instr;
    in_beat.code    = dec_code;
    in_beat.imm_sel = dec_imm_sel;
    in_beat.imm     = dec_imm;
    in_beat.illegal = dec_illegal;
  end

  // in_ready is forced low while reset is held so nothing is taken during reset
  assign in_ready = (EN_SKID ? in_ready_q : (!main_valid_q || out_ready)) && !rst;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid_q && out_ready;

  // next-state for main/skid: skid refills main ahead of any new input
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = in_beat;
      end
    end else if (accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_pc      = main_q.pc;
  assign out_instr   = main_q.instr;
  assign out_code    = main_q.code;
  assign out_imm_sel = main_q.imm_sel;
  assign out_imm     = main_q.imm;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a driver pushes expected beats on accept,
// a negedge monitor pops and compares on each output handshake. A second
// instance with EN_SYSTEM=0 shares all inputs and is checked alongside.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_pc, out_instr, out_imm;
  logic [3:0]  out_code;
  logic [2:0]  out_imm_sel;

  logic        ns_in_ready, ns_out_valid, ns_out_illegal;
  logic [31:0] ns_out_pc, ns_out_instr, ns_out_imm;
  logic [3:0]  ns_out_code;
  logic [2:0]  ns_out_imm_sel;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .EN_SYSTEM(1'b1), .EN_SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_code(out_code),
    .out_imm_sel(out_imm_sel), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  decode_stage #(.XLEN(32), .EN_SYSTEM(1'b0), .EN_SKID(1'b1)) dut_ns (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ns_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ns_out_valid), .out_ready(out_ready),
    .out_pc(ns_out_pc), .out_instr(ns_out_instr), .out_code(ns_out_code),
    .out_imm_sel(ns_out_imm_sel), .out_imm(ns_out_imm), .out_illegal(ns_out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  code;
    logic [2:0]  sel;
    logic [31:0] imm;
    logic        ill;
    logic [3:0]  code_ns;
    logic [2:0]  sel_ns;
    logic        ill_ns;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    int          idx;
  } exp_t;

  vec_t        vecs[14];
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_beats = 0;
  int          cyc = 0;
  logic [31:0] pc_next = 32'h0000_1000;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_pc, stall_instr;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input int k);
    int n;
    exp_t e;
    in_valid = 1'b1;
    in_instr = vecs[k].instr;
    in_pc    = pc_next;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 64'(in_ready), 64'd1);
    e.pc  = pc_next;
    e.idx = k;
    sb.push_back(e);
    pc_next = pc_next + 32'd4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // monitor: compare each handshaken beat against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && flush === 1'b0) begin
      if (stall_prev && out_valid === 1'b1) begin
        chk("stall_pc_stable", 64'(out_pc), 64'(stall_pc));
        chk("stall_instr_stable", 64'(out_instr), 64'(stall_instr));
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_beats++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got pc %0h expected no beat", out_pc);
        end else begin
          e = sb.pop_front();
          chk("pc", 64'(out_pc), 64'(e.pc));
          chk("instr", 64'(out_instr), 64'(vecs[e.idx].instr));
          chk("code", 64'(out_code), 64'(vecs[e.idx].code));
          chk("imm_sel", 64'(out_imm_sel), 64'(vecs[e.idx].sel));
          chk("imm", 64'(out_imm), 64'(vecs[e.idx].imm));
          chk("illegal", 64'(out_illegal), 64'(vecs[e.idx].ill));
          chk("ns_valid", 64'(ns_out_valid), 64'd1);
          chk("ns_pc", 64'(ns_out_pc), 64'(e.pc));
          chk("ns_code", 64'(ns_out_code), 64'(vecs[e.idx].code_ns));
          chk("ns_imm_sel", 64'(ns_out_imm_sel), 64'(vecs[e.idx].sel_ns));
          chk("ns_illegal", 64'(ns_out_illegal), 64'(vecs[e.idx].ill_ns));
        end
      end
      stall_prev  = (out_valid === 1'b1) && (out_ready === 1'b0);
      stall_pc    = out_pc;
      stall_instr = out_instr;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0, base;
    logic [31:0] pc_a;
    //          instr          code sel  imm           ill  code_ns sel_ns ill_ns
    vecs[0]  = '{32'h00500093, 4'd2, 3'd1, 32'h00000005, 1'b0, 4'd2, 3'd1, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 4'd5, 3'd3, 32'hFFFFFFFC, 1'b0, 4'd5, 3'd3, 1'b0};
    vecs[2]  = '{32'h800000B7, 4'd8, 3'd4, 32'h80000000, 1'b0, 4'd8, 3'd4, 1'b0};
    vecs[3]  = '{32'h00000000, 4'd0, 3'd0, 32'h00000000, 1'b1, 4'd0, 3'd0, 1'b1};
    vecs[4]  = '{32'h00000073, 4'hA, 3'd1, 32'h00000000, 1'b0, 4'd0, 3'd0, 1'b1};
    vecs[5]  = '{32'hFE112E23, 4'd4, 3'd2, 32'hFFFFFFFC, 1'b0, 4'd4, 3'd2, 1'b0};
    vecs[6]  = '{32'h0080006F, 4'd6, 3'd5, 32'h00000008, 1'b0, 4'd6, 3'd5, 1'b0};
    vecs[7]  = '{32'hFFF08067, 4'd7, 3'd1, 32'hFFFFFFFF, 1'b0, 4'd7, 3'd1, 1'b0};
    vecs[8]  = '{32'h00412083, 4'd3, 3'd1, 32'h00000004, 1'b0, 4'd3, 3'd1, 1'b0};
    vecs[9]  = '{32'h002081B3, 4'd1, 3'd0, 32'h00000000, 1'b0, 4'd1, 3'd0, 1'b0};
    vecs[10] = '{32'h12345297, 4'd9, 3'd4, 32'h12345000, 1'b0, 4'd9, 3'd4, 1'b0};
    vecs[11] = '{32'h0FF0000F, 4'hB, 3'd0, 32'h00000000, 1'b0, 4'd0, 3'd0, 1'b1};
    vecs[12] = '{32'h00500091, 4'd0, 3'd0, 32'h00000000, 1'b1, 4'd0, 3'd0, 1'b1};
    vecs[13] = '{32'h0000007F, 4'd0, 3'd0, 32'h00000000, 1'b1, 4'd0, 3'd0, 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 32'd0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    chk("rst_out_imm", 64'(out_imm), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // single addi: valid one cycle after accept
    out_ready = 1'b1;
    send(0);
    @(negedge clk);
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // back-to-back stream of all other vectors at one beat per cycle
    t0 = cyc;
    for (int k = 1; k < 14; k++) send(k);
    chk("stream_cycles", 64'(cyc - t0), 64'd13);
    repeat (3) @(posedge clk); #1;
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // backpressure: four beats into a stalled stage
    out_ready = 1'b0;
    pc_a = pc_next;
    fork
      begin
        for (int k = 0; k < 4; k++) send(0);
      end
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_head_pc", 64'(out_pc), 64'(pc_a));
    repeat (3) @(posedge clk); #1;
    chk("bp_still_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    base = n_beats;
    repeat (4) @(posedge clk); #1;
    chk("bp_four_in_four", 64'(n_beats - base), 64'd4);
    repeat (2) @(posedge clk); #1;
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // flush with main and skid full and a new beat offered
    out_ready = 1'b0;
    fork
      begin
        send(1);
        send(2);
      end
    join_none
    repeat (2) @(posedge clk); #2;
    flush = 1'b1; in_valid = 1'b1; in_instr = vecs[5].instr; in_pc = 32'hDEAD_0000;
    sb.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    base = n_beats;
    out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("flush_no_beats", 64'(n_beats - base), 64'd0);
    send(6);
    repeat (2) @(posedge clk); #1;
    chk("flush_recovered", 64'(sb.size()), 64'd0);

    // reset while a beat is stalled at the output
    out_ready = 1'b0;
    send(7);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rst_hold_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_pc", 64'(out_pc), 64'd0);
    chk("mid_rst_out_instr", 64'(out_instr), 64'd0);
    chk("mid_rst_out_imm", 64'(out_imm), 64'd0);
    chk("mid_rst_out_code", 64'(out_code), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(10);
    repeat (2) @(posedge clk); #1;
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
